mul_arbiter: RTL
================

MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 Parameter DATA_W, default 20, operand and result width.
REQ-002 Parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-003 Parameter TAG_DEPTH, default 16, maximum products in flight (power of two).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 req  input  NUM_REQ  per-requester multiply request, held until granted.
REQ-007 req_a, req_b  input  NUM_REQ*DATA_W each  packed operands, requester i at slice i.
REQ-008 gnt  output  NUM_REQ  one-hot grant, combinational, operands accepted this cycle.
REQ-009 res_valid  output  NUM_REQ  one-cycle pulse, result for requester i.
REQ-010 res_data  output  DATA_W  result, shared by all requesters, qualified by res_valid.
REQ-011 operation_nd  output  1  new-data strobe to MUL.
REQ-012 a, b  output  DATA_W each  operands to MUL.
REQ-013 operation_rfd  input  1  MUL ready-for-data.
REQ-014 rdy, result  input  1, DATA_W  MUL output valid and product.
REQ-015 err  output  1  sticky protocol error flag.

Function
REQ-016 Issue allowed in cycle T only when operation_rfd=1 and in-flight count < TAG_DEPTH.
REQ-017 When issue allowed and any req bit set, exactly one gnt bit asserts in T; otherwise gnt=0.
REQ-018 Default arbitration is round-robin: search starts at (last granted index + 1) mod NUM_REQ.
REQ-019 Granted operands appear on a, b with operation_nd=1 in T+1 (one register stage); operation_nd=0 otherwise.
REQ-020 Granted requester index is pushed into the tag FIFO in T+1, together with operation_nd.
REQ-021 When rdy=1 in cycle R with FIFO non-empty, FIFO pops; res_valid[tag]=1 and res_data=result in R+1.
REQ-022 MUL returns results in issue order; the block performs no reordering.
REQ-023 Push and pop in the same cycle leave the in-flight count unchanged; full + simultaneous pop still blocks issue that cycle (count registered).
REQ-024 rdy=1 with FIFO empty sets err, produces no res_valid, and leaves the count at 0 (no underflow).
REQ-025 Round-robin pointer and FIFO pointers wrap modulo NUM_REQ and TAG_DEPTH respectively.
REQ-026 req deasserted before grant is legal; no state is retained for it.

Reset
REQ-027 rst_n low clears, asynchronously: gnt-pointer to NUM_REQ-1 (first search starts at 0), FIFO empty, count 0, operation_nd 0, a/b 0, res_valid 0, res_data 0, err 0.
REQ-028 Reset mid-operation discards all in-flight tags; rdy pulses arriving after reset release with empty FIFO set err per REQ-024.
REQ-029 err clears only by reset.

Configuration
REQ-030 Macro MUL_ARB_FIXED_PRIO_EN: defined selects fixed priority (lowest index wins, pointer unused); undefined selects round-robin per REQ-018.

Structure
REQ-031 Package fft_mul_pkg holds DATA_W default, NUM_REQ default, TAG_DEPTH default and the tag index width constant.
REQ-032 Sub-module mul_tag_fifo: synchronous FIFO of requester indices, with push, pop, full, empty, count.

Verification (stub MUL, fixed latency 4, rfd=1 unless stated)
REQ-033 req=4'b0001, a=b=0x78000 -> gnt=0001 at T, operation_nd at T+1, res_valid=0001 with stub product at T+6.
REQ-034 req=4'b1111 held 8 cycles -> grants 0,1,2,3,0,1,2,3 in order; with MUL_ARB_FIXED_PRIO_EN -> gnt=0001 every cycle.
REQ-035 Stub latency 40, req=4'b0001 held -> exactly 16 grants, then gnt=0 until first rdy; issue resumes one cycle after count drops.
REQ-036 operation_rfd=0 for 3 cycles with req=4'b0010 -> gnt=0 those cycles, grant on first rfd=1 cycle.
REQ-037 Spurious rdy=1 after reset with no issue -> err=1 next cycle, res_valid stays 0, err persists until rst_n low.
REQ-038 rst_n pulsed low while 3 products in flight -> all outputs 0 immediately; subsequent 3 rdy pulses set err, no res_valid.

Source files
------------

// File: rtl/fft_mul_pkg.sv
// Shared defaults and index-width helpers for the multiplier arbiter slice.
package fft_mul_pkg;
  localparam int DATA_W_DEF    = 20;
  localparam int NUM_REQ_DEF   = 4;
  localparam int TAG_DEPTH_DEF = 16;
  localparam int TAG_W         = $clog2(NUM_REQ_DEF);

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mul_arbiter_if.sv
// Requester-side and multiplier-side signals of the arbiter; slave is the arbiter view.
interface mul_arbiter_if
  import fft_mul_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int NUM_REQ = NUM_REQ_DEF
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        res_valid;
  logic [DATA_W-1:0]         res_data;
  logic                      operation_nd;
  logic [DATA_W-1:0]         a;
  logic [DATA_W-1:0]         b;
  logic                      operation_rfd;
  logic                      rdy;
  logic [DATA_W-1:0]         result;

  modport slave (
    input  req, req_a, req_b, operation_rfd, rdy, result,
    output gnt, res_valid, res_data, operation_nd, a, b
  );

  modport master (
    output req, req_a, req_b, operation_rfd, rdy, result,
    input  gnt, res_valid, res_data, operation_nd, a, b
  );
endinterface

// File: rtl/mul_tag_fifo.sv
// Synchronous FIFO of requester indices, one entry per product in flight, in issue order.
module mul_tag_fifo
  import fft_mul_pkg::*;
#(
  parameter int DEPTH = TAG_DEPTH_DEF,
  parameter int W     = TAG_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_MAX = (PTR_W+1)'(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             push_ok, pop_ok;

  assign full     = (count == CNT_MAX);
  assign empty    = (count == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/mul_arbiter.sv
// Shares one pipelined multiplier among NUM_REQ requesters and routes results back by tag.
// Macro MUL_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module mul_arbiter
  import fft_mul_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int NUM_REQ   = NUM_REQ_DEF,
  parameter int TAG_DEPTH = TAG_DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  mul_arbiter_if.slave  bus,
  output logic          err
);
  localparam int IDX_W = idx_width(NUM_REQ);
  localparam int CNT_W = $clog2(TAG_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_V = CNT_W'(TAG_DEPTH);

  logic [IDX_W-1:0]   sel, nd_idx, pop_idx;
  logic               found, issue_ok, pop;
  logic               fifo_full, fifo_empty;
  logic [CNT_W-1:0]   fifo_count, occ;
  logic [NUM_REQ-1:0] gnt_c, rv_d, rv_q;
  logic [DATA_W-1:0]  nxt_a, nxt_b, a_q, b_q, rd_q;
  logic               nd_q;

  // A grant from last cycle is not in the FIFO yet, so it still counts as in flight.
  assign occ      = fifo_count + {{(CNT_W-1){1'b0}}, nd_q};
  assign issue_ok = bus.operation_rfd && !fifo_full && (occ < DEPTH_V);
  assign pop      = bus.rdy && !fifo_empty;

`ifdef MUL_ARB_FIXED_PRIO_EN
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && bus.req[i]) begin
        found = 1'b1;
        sel   = IDX_W'(i);
      end
    end
  end
`else
  logic [IDX_W-1:0] last_ptr, cand;

  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((int'(last_ptr) + i) % NUM_REQ);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  // Reset value makes the first search start at requester 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     last_ptr <= IDX_W'(NUM_REQ - 1);
    else if (found && issue_ok) last_ptr <= sel;
  end
`endif

  always_comb begin
    gnt_c = '0;
    nxt_a = '0;
    nxt_b = '0;
    if (issue_ok && found) gnt_c[sel] = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel == IDX_W'(i)) begin
        nxt_a = bus.req_a[i*DATA_W +: DATA_W];
        nxt_b = bus.req_b[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nd_q   <= 1'b0;
      nd_idx <= '0;
      a_q    <= '0;
      b_q    <= '0;
    end else begin
      nd_q <= |gnt_c;
      if (|gnt_c) begin
        nd_idx <= sel;
        a_q    <= nxt_a;
        b_q    <= nxt_b;
      end
    end
  end

  mul_tag_fifo #(
    .DEPTH (TAG_DEPTH),
    .W     (IDX_W)
  ) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (nd_q),
    .push_data (nd_idx),
    .pop       (pop),
    .pop_data  (pop_idx),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    rv_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pop && (pop_idx == IDX_W'(i))) rv_d[i] = 1'b1;
    end
  end

  // A result with no tag outstanding is a protocol error; it is dropped and latched in err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rv_q <= '0;
      rd_q <= '0;
      err  <= 1'b0;
    end else begin
      rv_q <= rv_d;
      if (pop) rd_q <= bus.result;
      if (bus.rdy && fifo_empty) err <= 1'b1;
    end
  end

  assign bus.gnt          = gnt_c;
  assign bus.operation_nd = nd_q;
  assign bus.a            = a_q;
  assign bus.b            = b_q;
  assign bus.res_valid    = rv_q;
  assign bus.res_data     = rd_q;
endmodule
